block_t_access_arbiter: RTL

//  Shares the AXI4-Lite slave port of the block_t register file among N_REQ
//  on-chip requesters using simple req/ack command ports. Arbitrates round-robin,

---
 rtl/block_t_access_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/block_t_access_arbiter.sv
// Round-robin arbiter sharing the block_t AXI4-Lite slave port among N_REQ req/ack requesters.
// Optional grant locking for atomic read-modify-write is enabled by defining BLOCK_T_ARB_LOCK_EN.
module block_t_access_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [N_REQ-1:0]                   i_req,
    input  logic [N_REQ-1:0]                   i_req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0]        i_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]        i_req_wdata,
    input  logic [N_REQ*(DATA_WIDTH/8)-1:0]    i_req_strb,
    input  logic [N_REQ-1:0]                   i_lock,
    output logic [N_REQ-1:0]                   o_ack,
    output logic [DATA_WIDTH-1:0]              o_rdata,
    output logic [1:0]                         o_resp,
    output logic                               o_awvalid,
    input  logic                               i_awready,
    output logic [ADDR_WIDTH-1:0]              o_awaddr,
    output logic [2:0]                         o_awprot,
    output logic                               o_wvalid,
    input  logic                               i_wready,
    output logic [DATA_WIDTH-1:0]              o_wdata,
    output logic [DATA_WIDTH/8-1:0]            o_wstrb,
    input  logic                               i_bvalid,
    output logic                               o_bready,
    input  logic [1:0]                         i_bresp,
    output logic                               o_arvalid,
    input  logic                               i_arready,
    output logic [ADDR_WIDTH-1:0]              o_araddr,
    output logic [2:0]                         o_arprot,
    input  logic                               i_rvalid,
    output logic                               o_rready,
    input  logic [DATA_WIDTH-1:0]              i_rdata,
    input  logic [1:0]                         i_rresp
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_q, rr_d;
    logic [IDX_W-1:0]        grant_q, grant_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic                    found;
    logic [IDX_W-1:0]        sel;
    int                      cand;

    // First requesting index at or after the rotating pointer, wrapping mod N_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && i_req[cand]) begin
                found = 1'b1;
                sel   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d   = sel;
                    write_d   = i_req_write[sel];
                    addr_d    = i_req_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = i_req_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                    strb_d    = i_req_strb[int'(sel)*STRB_WIDTH +: STRB_WIDTH];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    resp_d    = '0;
                    state_d   = i_req_write[sel] ? S_WR_ADDR_DATA : S_RD_ADDR;
                end
            end
            S_WR_ADDR_DATA: begin
                // AW and W complete independently; move on once both have been taken.
                aw_done_d = aw_done_q | i_awready;
                w_done_d  = w_done_q | i_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (i_bvalid) begin
                    resp_d  = i_bresp;
                    state_d = S_DONE;
                end
            end
            S_RD_ADDR: begin
                if (i_arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (i_rvalid) begin
                    rdata_d = i_rdata;
                    resp_d  = i_rresp;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`ifdef BLOCK_T_ARB_LOCK_EN
                if (i_lock[grant_q]) begin
                    rr_d = grant_q;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef BLOCK_T_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^i_lock;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        o_ack = '0;
        if (state_q == S_DONE) begin
            o_ack[grant_q] = 1'b1;
        end
        o_rdata   = (state_q == S_DONE) ? rdata_q : '0;
        o_resp    = (state_q == S_DONE) ? resp_q : 2'b00;
        o_awvalid = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
        o_wvalid  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
        o_bready  = (state_q == S_WR_RESP);
        o_arvalid = (state_q == S_RD_ADDR);
        o_rready  = (state_q == S_RD_DATA);
        o_awaddr  = addr_q;
        o_araddr  = addr_q;
        o_wdata   = wdata_q;
        o_wstrb   = strb_q;
        o_awprot  = 3'b000;
        o_arprot  = 3'b000;
    end

endmodule
